// File: rtl/fpm_adder_arbiter.sv
// Purpose: round-robin share of one external 32-bit adder between mantissa rounding (req0)
//          and exponent add/bias (req1), returning a tagged {sum, cout} response.
// Latency: pair accepted at edge T is presented on resp_* after edge T+1; one result/cycle.
// Backpressure: resp_ready low stalls stage 2, then stage 1, then drops both req*_ready.
// Ports: clk/rst (sync, active-high); req0_*/req1_* valid/ready operand pairs;
//        add_a/add_b/add_sum/add_cout connect the shared combinational adder;
//        resp_valid/resp_ready/resp_sum/resp_cout/resp_id tagged result.
module fpm_adder_arbiter #(
  parameter int W    = 32,
  parameter int ID_W = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [W-1:0]    req0_a,
  input  logic [W-1:0]    req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [W-1:0]    req1_a,
  input  logic [W-1:0]    req1_b,
  output logic [W-1:0]    add_a,
  output logic [W-1:0]    add_b,
  input  logic [W-1:0]    add_sum,
  input  logic            add_cout,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [W-1:0]    resp_sum,
  output logic            resp_cout,
  output logic [ID_W-1:0] resp_id
);

  // Stage 1: operand register feeding the shared adder.
  logic            s1_valid_q, s1_valid_d;
  logic [W-1:0]    s1_a_q, s1_a_d;
  logic [W-1:0]    s1_b_q, s1_b_d;
  logic [ID_W-1:0] s1_id_q, s1_id_d;

  // Stage 2: result register.
  logic            s2_valid_q, s2_valid_d;
  logic [W-1:0]    s2_sum_q, s2_sum_d;
  logic            s2_cout_q, s2_cout_d;
  logic [ID_W-1:0] s2_id_q, s2_id_d;

  // Priority pointer: 0 favours req0 when both are valid, 1 favours req1.
  logic            ptr_q, ptr_d;

  logic s2_adv, s1_adv;
  logic grant0, grant1;
  logic acc0, acc1;

  always_comb begin
    s2_adv = !s2_valid_q || resp_ready;
    s1_adv = !s1_valid_q || s2_adv;

    grant0 = req0_valid && (!req1_valid || !ptr_q);
    grant1 = req1_valid && (!req0_valid || ptr_q);

    req0_ready = grant0 && s1_adv && !rst;
    req1_ready = grant1 && s1_adv && !rst;

    acc0 = req0_valid && req0_ready;
    acc1 = req1_valid && req1_ready;

    // Hold by default.
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_id_d    = s1_id_q;
    s2_valid_d = s2_valid_q;
    s2_sum_d   = s2_sum_q;
    s2_cout_d  = s2_cout_q;
    s2_id_d    = s2_id_q;
    ptr_d      = ptr_q;

    // The adder is combinational off the stage-1 registers, so its outputs
    // belong to the stage-1 entry and are captured together with its tag.
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      s2_sum_d   = add_sum;
      s2_cout_d  = add_cout;
      s2_id_d    = s1_id_q;
    end

    if (s1_adv) begin
      s1_valid_d = acc0 || acc1;
      if (acc0) begin
        s1_a_d  = req0_a;
        s1_b_d  = req0_b;
        s1_id_d = ID_W'(0);
      end else if (acc1) begin
        s1_a_d  = req1_a;
        s1_b_d  = req1_b;
        s1_id_d = ID_W'(1);
      end
    end

    // Pointer moves to the other requester only on an accepted handshake.
    if (acc0) begin
      ptr_d = 1'b1;
    end else if (acc1) begin
      ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_sum_q   <= '0;
      s2_cout_q  <= 1'b0;
      s2_id_q    <= '0;
      ptr_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_sum_q   <= s2_sum_d;
      s2_cout_q  <= s2_cout_d;
      s2_id_q    <= s2_id_d;
      ptr_q      <= ptr_d;
    end
  end

  assign add_a      = s1_a_q;
  assign add_b      = s1_b_q;
  assign resp_valid = s2_valid_q;
  assign resp_sum   = s2_sum_q;
  assign resp_cout  = s2_cout_q;
  assign resp_id    = s2_id_q;

endmodule

// File: tb/tb_fpm_adder_arbiter.sv
module tb_fpm_adder_arbiter;
  localparam int W    = 32;
  localparam int ID_W = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            req0_valid, req0_ready;
  logic [W-1:0]    req0_a, req0_b;
  logic            req1_valid, req1_ready;
  logic [W-1:0]    req1_a, req1_b;
  logic [W-1:0]    add_a, add_b, add_sum;
  logic            add_cout;
  logic            resp_valid, resp_ready;
  logic [W-1:0]    resp_sum;
  logic            resp_cout;
  logic [ID_W-1:0] resp_id;

  always #5 clk = ~clk;

  // The shared adder sits outside the arbiter.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

  fpm_adder_arbiter #(.W(W), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .add_cout(add_cout),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_sum(resp_sum), .resp_cout(resp_cout), .resp_id(resp_id)
  );

  // Reference model: ordered list of accepted pairs still inside the block.
  typedef struct {
    logic         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           kacc;   // clock edge at which the pair was accepted
  } item_t;

  item_t        q[$];
  logic         mptr = 1'b0;      // requester favoured on contention
  int           k = 0;            // rising edges seen
  int           tests = 0;
  int           fails = 0;
  logic         pv [2];
  logic [W-1:0] pa [2];
  logic [W-1:0] pb [2];
  logic         held [2];         // pair was offered last cycle and not taken
  logic         last_acc0, last_acc1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  // One clock cycle: drive at negedge, check 2ns later, update model, cross posedge.
  task automatic cyc(input logic rr, output logic o_acc0, output logic o_acc1);
    int           n;
    logic         g0, g1, can, expv;
    logic [W:0]   s;
    item_t        it;
    @(negedge clk);
    req0_valid = pv[0]; req0_a = pa[0]; req0_b = pb[0];
    req1_valid = pv[1]; req1_a = pa[1]; req1_b = pb[1];
    resp_ready = rr;
    #2;
    if (held[0]) chk("hold_valid0", req0_valid, 1'b1);
    if (held[1]) chk("hold_valid1", req1_valid, 1'b1);
    n   = q.size();
    g0  = pv[0] && (!pv[1] || mptr == 1'b0);
    g1  = pv[1] && (!pv[0] || mptr == 1'b1);
    can = (n < 2) || rr;
    chk("req0_ready", req0_ready, g0 && can);
    chk("req1_ready", req1_ready, g1 && can);
    expv = 1'b0;
    if (n == 2) expv = 1'b1;
    else if (n == 1) expv = (q[0].kacc < k);
    chk("resp_valid", resp_valid, expv);
    if (resp_valid && n > 0) begin
      s = {1'b0, q[0].a} + {1'b0, q[0].b};
      chk("resp_sum", resp_sum, s[W-1:0]);
      chk("resp_cout", resp_cout, s[W]);
      chk("resp_id", resp_id, q[0].id);
      if (rr) void'(q.pop_front());
    end
    o_acc0 = pv[0] && req0_ready;
    o_acc1 = pv[1] && req1_ready;
    if (o_acc0) begin
      it = '{1'b0, pa[0], pb[0], k + 1};
      q.push_back(it);
      mptr = 1'b1;
    end else if (o_acc1) begin
      it = '{1'b1, pa[1], pb[1], k + 1};
      q.push_back(it);
      mptr = 1'b0;
    end
    held[0] = pv[0] && !o_acc0;
    held[1] = pv[1] && !o_acc1;
    @(posedge clk);
    k++;
  endtask

  task automatic step(input bit w0, input bit w1, input bit rr);
    logic a0, a1;
    if (!pv[0] && w0) begin pv[0] = 1'b1; pa[0] = pick(); pb[0] = pick(); end
    if (!pv[1] && w1) begin pv[1] = 1'b1; pa[1] = pick(); pb[1] = pick(); end
    cyc(rr, a0, a1);
    last_acc0 = a0;
    last_acc1 = a1;
    if (a0) pv[0] = 1'b0;
    if (a1) pv[1] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req0_valid = pv[0]; req1_valid = pv[1];
    resp_ready = 1'b1;
    #2;
    chk("rst_req0_ready", req0_ready, 1'b0);
    chk("rst_req1_ready", req1_ready, 1'b0);
    @(posedge clk);
    k++;
    @(negedge clk);
    rst = 1'b0;
    pv[0] = 1'b0; pv[1] = 1'b0; held[0] = 1'b0; held[1] = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
    q.delete();
    mptr = 1'b0;
    #2;
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_sum", resp_sum, '0);
    chk("rst_resp_cout", resp_cout, 1'b0);
    chk("rst_resp_id", resp_id, '0);
    chk("rst_add_a", add_a, '0);
    chk("rst_add_b", add_b, '0);
    @(posedge clk);
    k++;
  endtask

  initial begin
    int acc_cnt;
    rst = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0;
    resp_ready = 1'b0;
    pv[0] = 1'b0; pv[1] = 1'b0; pa[0] = '0; pb[0] = '0; pa[1] = '0; pb[1] = '0;
    held[0] = 1'b0; held[1] = 1'b0;
    do_reset();

    // Carry-out boundary: 1 + 0xFFFF_FFFF -> sum 0, cout 1, id 0.
    pv[0] = 1'b1; pa[0] = 32'h0000_0001; pb[0] = 32'hFFFF_FFFF;
    step(0, 0, 1);
    chk("t1_accept", last_acc0, 1'b1);
    step(0, 0, 1);
    step(0, 0, 1);

    // Contention: grants alternate starting with requester 0.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 1);
      chk("t2_grant0", last_acc0, (i % 2) == 0);
      chk("t2_grant1", last_acc1, (i % 2) == 1);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 1);

    // Backpressure: three pairs offered, only two fit.
    do_reset();
    acc_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0);
      if (last_acc0) acc_cnt++;
    end
    chk("t3_accepted", acc_cnt, 2);
    for (int i = 0; i < 4; i++) step(0, 0, 1);
    chk("t3_drained", q.size(), 0);

    // req1 alone back-to-back, then contention goes to requester 0.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1);
      chk("t4_req1_acc", last_acc1, 1'b1);
    end
    step(1, 1, 1);
    chk("t4_contend0", last_acc0, 1'b1);
    for (int i = 0; i < 3; i++) step(0, 0, 1);

    // Reset with both stages occupied: nothing stale, pointer back at 0.
    do_reset();
    step(1, 0, 0);
    step(1, 0, 0);
    chk("t5_full", q.size(), 2);
    do_reset();
    step(1, 1, 1);
    chk("t5_ptr0", last_acc0, 1'b1);
    for (int i = 0; i < 3; i++) step(0, 0, 1);

    // Random traffic and backpressure.
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
    end
    pv[0] = 1'b0; pv[1] = 1'b0; held[0] = 1'b0; held[1] = 1'b0;
    for (int i = 0; i < 10 && q.size() != 0; i++) step(0, 0, 1);
    chk("final_drain", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
